// File: rtl/ring_pkg.sv
// Shared types and constants for the ring counter monitor.
package ring_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_REV_W = 8;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_ERROR    = 2'd3
    } ring_state_e;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_NOT_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_WRONG_ROT  = 2'b10;

endpackage

// File: rtl/onehot_enc.sv
// One-hot check and binary encode of a ring sample.
// Latency 0 (combinational); no flow control.
module onehot_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] q,
    output logic             onehot,
    output logic [IDX_W-1:0] idx
);

    logic w_seen;
    logic w_multi;

    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        idx     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        onehot = w_seen & ~w_multi;
    end

endmodule

// File: rtl/ring_monitor.sv
// Watches a one-hot ring counter: locks onto correct rotation, counts revolutions, flags errors.
// Latency 1 cycle from q_in to all outputs; no backpressure, one sample per clock.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int REV_W = DEFAULT_REV_W,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] q_in,
    input  logic             ring_clr,
    input  logic             err_clr,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_count,
    output logic             err,
    output logic [1:0]       err_code
);

    ring_state_e      r_state;
    ring_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [IDX_W-1:0] r_idx;
    logic             r_idx_valid;
    logic             r_rev_tick;
    logic [REV_W-1:0] r_rev_count;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic             w_onehot;
    logic [IDX_W-1:0] w_enc_idx;
    logic [WIDTH-1:0] w_rotl;
    logic             w_succ;
    logic             w_in_lock;
    logic             w_bad_lock;
    logic             w_wrap;

    onehot_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .q      (q_in),
        .onehot (w_onehot),
        .idx    (w_enc_idx)
    );

    assign w_rotl     = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_succ     = w_onehot && (q_in == w_rotl);
    // ring_clr pre-empts both error detection and revolution counting on its edge.
    assign w_in_lock  = (r_state == ST_LOCKED) && !ring_clr;
    assign w_bad_lock = w_in_lock && !w_succ;
    assign w_wrap     = w_in_lock && w_succ && r_prev[WIDTH-1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_onehot) w_state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (!w_onehot)  w_state_nxt = ST_UNLOCKED;
                else if (w_succ) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!w_succ) w_state_nxt = ST_ERROR;
            end
            ST_ERROR: begin
                if (err_clr) w_state_nxt = ST_UNLOCKED;
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
        if (ring_clr) begin
            w_state_nxt = ST_UNLOCKED;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_UNLOCKED;
            r_prev      <= '0;
            r_idx       <= '0;
            r_idx_valid <= 1'b0;
            r_rev_tick  <= 1'b0;
            r_rev_count <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= q_in;
            r_idx_valid <= w_onehot;
            if (w_onehot) begin
                r_idx <= w_enc_idx;
            end
            r_rev_tick <= w_wrap;
            if (w_wrap && (r_rev_count != {REV_W{1'b1}})) begin
                r_rev_count <= r_rev_count + REV_W'(1);
            end
            // A bad sample can only be seen from LOCKED, so the code latches once per episode.
            if (w_bad_lock) begin
                r_err      <= 1'b1;
                r_err_code <= w_onehot ? ERR_WRONG_ROT : ERR_NOT_ONEHOT;
            end else if (err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end
        end
    end

    assign idx       = r_idx;
    assign idx_valid = r_idx_valid;
    assign locked    = (r_state == ST_LOCKED);
    assign rev_tick  = r_rev_tick;
    assign rev_count = r_rev_count;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_ring_monitor.sv
// Randomized and directed bench for ring_monitor against a behavioural ring model.
module tb_ring_monitor;

    logic       clk;
    logic       clr_n;
    logic [3:0] q_in;
    logic       ring_clr;
    logic       err_clr;

    logic [1:0] idx, idx2;
    logic       idx_valid, idx_valid2;
    logic       locked, locked2;
    logic       rev_tick, rev_tick2;
    logic [7:0] rev_count;
    logic [1:0] rev_count2;
    logic       err, err2;
    logic [1:0] err_code, err_code2;

    int n_pass = 0;
    int n_chk  = 0;
    bit cmp_en = 0;

    ring_monitor #(.WIDTH(4), .REV_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .q_in(q_in), .ring_clr(ring_clr), .err_clr(err_clr),
        .idx(idx), .idx_valid(idx_valid), .locked(locked), .rev_tick(rev_tick),
        .rev_count(rev_count), .err(err), .err_code(err_code)
    );

    ring_monitor #(.WIDTH(4), .REV_W(2)) dut2 (
        .clk(clk), .clr_n(clr_n), .q_in(q_in), .ring_clr(ring_clr), .err_clr(err_clr),
        .idx(idx2), .idx_valid(idx_valid2), .locked(locked2), .rev_tick(rev_tick2),
        .rev_count(rev_count2), .err(err2), .err_code(err_code2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_ERR = 3;
    int m_mode, m_prev, m_idx, m_vld, m_tick, m_cnt, m_err, m_code;

    function automatic int rotl(input int p);
        return ((p * 2) + (p / 8)) % 16;
    endfunction

    function automatic int pos_of(input int p);
        for (int i = 0; i < 4; i++) if (p == (1 << i)) return i;
        return 0;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_mode = M_IDLE; m_prev = 0; m_idx = 0; m_vld = 0;
            m_tick = 0; m_cnt = 0; m_err = 0; m_code = 0;
        end else begin
            int q, nm;
            bit oh, good;
            q    = int'(q_in);
            oh   = ($countones(q_in) == 1);
            good = oh && (q == rotl(m_prev));
            m_tick = (m_mode == M_LOCK && !ring_clr && good && m_prev == 8) ? 1 : 0;
            m_cnt += m_tick;
            if (m_mode == M_LOCK && !ring_clr && !good) begin
                m_err = 1; m_code = oh ? 2 : 1;
            end else if (err_clr) begin
                m_err = 0; m_code = 0;
            end
            nm = m_mode;
            if (ring_clr) nm = M_IDLE;
            else case (m_mode)
                M_IDLE: nm = oh ? M_ACQ : M_IDLE;
                M_ACQ:  nm = !oh ? M_IDLE : (good ? M_LOCK : M_ACQ);
                M_LOCK: nm = good ? M_LOCK : M_ERR;
                default: nm = err_clr ? M_IDLE : M_ERR;
            endcase
            m_mode = nm;
            m_prev = q;
            m_vld  = oh;
            if (oh) m_idx = pos_of(q);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("idx",        idx,        m_idx);
            chk("idx_valid",  idx_valid,  m_vld);
            chk("locked",     locked,     (m_mode == M_LOCK) ? 1 : 0);
            chk("rev_tick",   rev_tick,   m_tick);
            chk("rev_count",  rev_count,  sat(m_cnt, 255));
            chk("err",        err,        m_err);
            chk("err_code",   err_code,   m_code);
            chk("locked2",    locked2,    (m_mode == M_LOCK) ? 1 : 0);
            chk("rev_tick2",  rev_tick2,  m_tick);
            chk("rev_count2", rev_count2, sat(m_cnt, 3));
            chk("err_code2",  err_code2,  m_code);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [3:0] q, input logic rc, input logic ec);
        q_in = q; ring_clr = rc; err_clr = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_idx"},   idx, 0);
        chk({tag, "_vld"},   idx_valid, 0);
        chk({tag, "_lock"},  locked, 0);
        chk({tag, "_tick"},  rev_tick, 0);
        chk({tag, "_cnt"},   rev_count, 0);
        chk({tag, "_err"},   err, 0);
        chk({tag, "_code"},  err_code, 0);
        chk({tag, "_cnt2"},  rev_count2, 0);
    endtask

    // Called just after a rising edge: drops clr_n between edges and checks outputs before the next edge.
    task automatic mid_reset(input bit check_now);
        #2 clr_n = 1'b0;
        #1;
        if (check_now) chk_reset_vals("async_rst");
        @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    initial begin
        logic [3:0] cur;
        int ticks;
        clr_n = 1'b0; q_in = 4'b0; ring_clr = 1'b0; err_clr = 1'b0;
        #2;
        chk_reset_vals("reset");
        #10 clr_n = 1'b1;
        cmp_en = 1;

        // Basic lock and one revolution.
        cyc(4'b0001, 0, 0); chk("s1_lock", locked, 0); chk("s1_idx", idx, 0); chk("s1_vld", idx_valid, 1);
        cyc(4'b0010, 0, 0); chk("s2_lock", locked, 1); chk("s2_idx", idx, 1);
        cyc(4'b0100, 0, 0); chk("s3_idx", idx, 2);
        cyc(4'b1000, 0, 0); chk("s4_idx", idx, 3); chk("s4_tick", rev_tick, 0);
        cyc(4'b0001, 0, 0); chk("s5_idx", idx, 0); chk("s5_tick", rev_tick, 1); chk("s5_cnt", rev_count, 1);
        cyc(4'b0010, 0, 0); chk("s6_tick", rev_tick, 0);

        // Not-one-hot error, sticky code, clear.
        cyc(4'b0110, 0, 0); chk("e1_err", err, 1); chk("e1_code", err_code, 1); chk("e1_lock", locked, 0);
        chk("e1_idx_hold", idx, 1); chk("e1_vld", idx_valid, 0);
        cyc(4'b0011, 0, 0); chk("e1_code_held", err_code, 1);
        cyc(4'b0100, 0, 0); chk("e1_code_held2", err_code, 1);
        cyc(4'b0100, 0, 1); chk("e1_clr_err", err, 0); chk("e1_clr_code", err_code, 0); chk("e1_clr_lock", locked, 0);

        // Wrong rotation.
        cyc(4'b1000, 0, 0);
        cyc(4'b0001, 0, 0); chk("e2_lock", locked, 1); chk("e2_notick", rev_tick, 0);
        cyc(4'b0010, 0, 0);
        cyc(4'b1000, 0, 0); chk("e2_err", err, 1); chk("e2_code", err_code, 2);
        cyc(4'b0001, 0, 1); chk("e2_clr", err, 0);

        // ring_clr while locked.
        cyc(4'b0010, 0, 0);
        cyc(4'b0100, 0, 0);
        cyc(4'b1000, 0, 0); chk("rc_pre_lock", locked, 1);
        cyc(4'b0001, 1, 0); chk("rc1_lock", locked, 0); chk("rc1_err", err, 0); chk("rc1_tick", rev_tick, 0);
        cyc(4'b0001, 1, 0); chk("rc2_lock", locked, 0);
        cyc(4'b0001, 0, 0); chk("rc3_lock", locked, 0); chk("rc3_err", err, 0);
        cyc(4'b0010, 0, 0); chk("rc_relock", locked, 1);

        // Five revolutions: narrow counter saturates, ticks keep coming.
        cur = 4'b0010; ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cur = 4'(rotl(int'(cur)));
            cyc(cur, 0, 0);
            if (rev_tick) ticks++;
        end
        chk("rev5_ticks", ticks, 5);
        chk("rev5_cnt8", rev_count, 6);
        chk("rev5_cnt2", rev_count2, 3);

        // Async reset mid-revolution, then relock from scratch.
        cyc(4'b0001, 0, 0);
        cyc(4'b0010, 0, 0);
        mid_reset(1);
        cyc(4'b0100, 0, 0); chk("post_rst_lock", locked, 0);
        cyc(4'b1000, 0, 0); chk("post_rst_relock", locked, 1);
        cur = 4'b1000;

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] q;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                mid_reset(0);
                cur = 4'b0;
            end else begin
                if (r < 85 && $countones(cur) == 1) q = 4'(rotl(int'(cur)));
                else if (r < 93) q = 4'(1 << $urandom_range(0, 3));
                else q = 4'($urandom_range(0, 15));
                cyc(q, ($urandom_range(0, 39) == 0), ($urandom_range(0, 14) == 0));
                cur = q;
            end
        end

        @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
